// File: rtl/bcd_addsub_seq_if.sv
// Operand/result handshake bundle for the digit-serial BCD adder/subtractor.
// Signal names match the original flat port list so integrators can map them one-to-one.
interface bcd_addsub_seq_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  io_in_valid;
  logic                  io_in_ready;
  logic [4*DIGITS-1:0]   io_A;
  logic [4*DIGITS-1:0]   io_B;
  logic                  io_C;
  logic                  io_Sub;
  logic                  io_out_valid;
  logic                  io_out_ready;
  logic [4*DIGITS-1:0]   io_Sum;
  logic                  io_Carry;
  logic                  io_Invalid;

  modport master (
    output io_in_valid, io_A, io_B, io_C, io_Sub, io_out_ready,
    input  io_in_ready, io_out_valid, io_Sum, io_Carry, io_Invalid
  );

  modport slave (
    input  io_in_valid, io_A, io_B, io_C, io_Sub, io_out_ready,
    output io_in_ready, io_out_valid, io_Sum, io_Carry, io_Invalid
  );
endinterface

// File: rtl/bcd_addsub_seq.sv
// Digit-serial packed-BCD adder/subtractor, DPC digits per clock, LSD first.
// Subtraction uses nines-complement of B with inverted carry-in (ten's complement result).
module bcd_addsub_seq #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DPC    = 1
) (
  input logic            clock,
  input logic            reset,
  bcd_addsub_seq_if.slave io
);
  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = 4 * DPC;
  localparam int unsigned S  = DIGITS / DPC;
  localparam int unsigned SW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic            sub_q, sub_d, carry_q, carry_d, inv_q, inv_d;
  logic            cout_q, cout_d, invout_q, invout_d, valid_q, valid_d;
  logic [SW-1:0]   step_q, step_d;

  logic            in_ready;
  logic            accept;
  logic [CW-1:0]   chunk;
  logic            chain_c;
  logic            chunk_inv;
  logic [3:0]      dig_a, dig_b_raw, dig_b;
  logic [4:0]      dig_s;

  // Operand registers shift right each step, so the active digits always sit at the bottom.
  always_comb begin
    chain_c   = carry_q;
    chunk     = '0;
    chunk_inv = 1'b0;
    dig_a     = '0;
    dig_b_raw = '0;
    dig_b     = '0;
    dig_s     = '0;
    for (int unsigned i = 0; i < DPC; i++) begin
      dig_a     = a_q[4*i +: 4];
      dig_b_raw = b_q[4*i +: 4];
      dig_b     = sub_q ? (4'd9 - dig_b_raw) : dig_b_raw;
      dig_s     = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, chain_c};
      chunk_inv = chunk_inv | (dig_a > 4'd9) | (dig_b_raw > 4'd9);
      if (dig_s > 5'd9) begin
        chunk[4*i +: 4] = dig_s[3:0] + 4'd6;
        chain_c         = 1'b1;
      end else begin
        chunk[4*i +: 4] = dig_s[3:0];
        chain_c         = 1'b0;
      end
    end
  end

  always_comb begin
    in_ready = reset & ((state_q == IDLE) | ((state_q == DONE) & io.io_out_ready));
    accept   = io.io_in_valid & in_ready;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    sum_d    = sum_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    inv_d    = inv_q;
    cout_d   = cout_q;
    invout_d = invout_q;
    valid_d  = valid_q;
    step_d   = step_q;

    case (state_q)
      RUN: begin
        a_d     = a_q >> CW;
        b_d     = b_q >> CW;
        res_d   = res_q >> CW;
        res_d[W-1 -: CW] = chunk;
        carry_d = chain_c;
        inv_d   = inv_q | chunk_inv;
        step_d  = step_q + 1'b1;
        if (step_q == SW'(S - 1)) begin
          sum_d    = res_d;
          cout_d   = chain_c;
          invout_d = inv_d;
          valid_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (io.io_out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    // Accept can only fire from IDLE or a draining DONE, so it overrides the case above.
    if (accept) begin
      a_d     = io.io_A;
      b_d     = io.io_B;
      sub_d   = io.io_Sub;
      carry_d = io.io_C ^ io.io_Sub;
      step_d  = '0;
      inv_d   = 1'b0;
      valid_d = 1'b0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      sum_q    <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      inv_q    <= 1'b0;
      cout_q   <= 1'b0;
      invout_q <= 1'b0;
      valid_q  <= 1'b0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      sum_q    <= sum_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      inv_q    <= inv_d;
      cout_q   <= cout_d;
      invout_q <= invout_d;
      valid_q  <= valid_d;
      step_q   <= step_d;
    end
  end

  assign io.io_in_ready  = in_ready;
  assign io.io_out_valid = valid_q;
  assign io.io_Sum       = sum_q;
  assign io.io_Carry     = cout_q;
  assign io.io_Invalid   = invout_q;
endmodule

// File: doc/bcd_addsub_seq.md
Name: bcd_addsub_seq

Overview:
Parametrised, digit-serial packed-BCD adder/subtractor with valid/ready handshakes on both sides. It is the sequential successor to the fixed 4-digit combinational BCD ripple adder. Width (digit count) and throughput (digits per cycle) are configurable, and it adds a subtract mode and an invalid-digit flag. It sits between operand producers and result consumers in the decimal arithmetic datapath.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1)
DPC, 1, digits processed per clock in RUN; must divide DIGITS (legal 1..DIGITS)

Ports:
clock  input  1  sole clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset at the clock edge)
io_in_valid  input  1  operand bundle valid
io_in_ready  output  1  block can accept operands
io_A  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]
io_B  input  4*DIGITS  operand B, packed BCD
io_C  input  1  carry-in (add) / borrow-in (sub)
io_Sub  input  1  0 = add, 1 = subtract
io_out_valid  output  1  result valid
io_out_ready  input  1  consumer accepts result
io_Sum  output  4*DIGITS  packed BCD result
io_Carry  output  1  add: decimal carry-out; sub: 1 = no borrow (A >= B+C)
io_Invalid  output  1  some digit of A or B was >9 in this operation

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (reset==0 at edge): state=IDLE; io_out_valid=0, io_Sum=0, io_Carry=0, io_Invalid=0; operand, carry and step registers=0. io_in_ready=0 while reset is low.
- States: IDLE, RUN, DONE. S = DIGITS/DPC steps.
- io_in_ready = (state==IDLE) | (state==DONE & io_out_ready).
- Accept = io_in_valid & io_in_ready. On accept:
  - Latch A.
  - Latch B, nines-complemented per digit (9-d, 4-bit) when io_Sub=1.
  - Latch Sub.
  - Carry reg = io_C when add; carry reg = ~io_C when sub.
  - Step=0, Invalid reg = 0, state->RUN.
- RUN, each cycle, for DPC digits starting at digit step*DPC, chained LSD first:
  - s = a + b' + cin (5-bit).
  - If s>9: digit = (s+6)[3:0], cout = 1. Otherwise digit = s[3:0], cout = 0.
  - The raw input a or b>9 sets Invalid reg; the arithmetic is still performed per the rule above.
  - Result digits are written into a result shift/position register. Carry reg = last cout.
  - After step S-1: io_Sum, io_Carry and io_Invalid are loaded, io_out_valid=1, state->DONE.
- Latency: io_out_valid rises exactly S clocks after the accept edge. DPC=DIGITS gives 1 clock.
- DONE: outputs are held stable while io_out_valid & ~io_out_ready (no change to Sum/Carry/Invalid).
  - io_out_ready & ~io_in_valid -> IDLE, io_out_valid=0 next cycle. io_Sum, io_Carry and io_Invalid hold their last values (don't-care to consumer).
  - io_out_ready & io_in_valid -> accept the new operands in the same cycle, state->RUN, io_out_valid=0 next cycle. Steady-state throughput is one operation per S+1 clocks.
- io_in_valid is ignored in RUN. Inputs io_A, io_B, io_C and io_Sub are only sampled at accept.
- Subtract result: Sum = (A - B - C) mod 10^DIGITS in ten's complement; io_Carry=0 signals a negative result.
- Reset mid-RUN or mid-DONE aborts the operation: no io_out_valid pulse, and pending results are discarded.
- No combinational path from io_A, io_B, io_C or io_Sub to any output. io_in_ready depends combinationally only on state, io_out_ready and reset.

Test Plan:
- DIGITS=4, DPC=1; add A=0x1234, B=0x5678, C=0 -> Sum=0x6912, Carry=0, Invalid=0; io_out_valid rises 4 clocks after accept.
- Add A=0x9999, B=0x0001, C=0 -> Sum=0x0000, Carry=1. Add A=0x9999, B=0x9999, C=1 -> Sum=0x9999, Carry=1.
- Sub A=0x0500, B=0x0123, C=0 -> Sum=0x0377, Carry=1. Sub A=0x0123, B=0x0500, C=0 -> Sum=0x9623, Carry=0. Sub A=0x0000, B=0x0000, C=1 -> Sum=0x9999, Carry=0.
- Backpressure: io_out_ready=0 for 5 cycles -> Sum/Carry stable and io_in_ready=0 throughout. Then io_out_ready=1 with io_in_valid=1 in the same cycle -> back-to-back accept and correct second result.
- Invalid: add A=0x00A0, B=0x0000, C=0 -> Invalid=1, Sum=0x0100, Carry=0. The next valid operation returns Invalid=0.
- Reset low in 2nd RUN cycle -> no io_out_valid. io_in_ready=1 the cycle after reset returns high. With DIGITS=8, DPC=4: add 0x99999999 + 1 -> Sum=0, Carry=1, latency 2 clocks.
